led_ring_decoder: RTL and testbench
===================================

Name: led_ring_decoder

Overview:
- Receive-side monitor for the 16-bit LED ring-shift pattern generated by the button/switch LED shifter.
- Samples the LED bus on a strobe, checks that the pattern is a legal circular run of ones, and locks onto it.
- Recovers the switch setting (run length − 1), tracks the head position, and counts steps and full revolutions.
- Flags any illegal pattern or illegal transition. Used in self-checking top-levels and as a loopback checker.

Parameters:
MAX_LEN, 8, largest legal run length (1..15); runs longer than this are illegal shapes.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
sample  input  1  qualifies led_in this cycle
led_in  input  16  LED pattern under observation
resync  input  1  single-cycle request to leave FAULT/TRACK and return to IDLE
locked  output  1  decoder is in TRACK
switch_out  output  3  recovered switch value = run length − 1 (MAX_LEN=8 gives 0..7)
head  output  4  bit index of leading end of run
steps  output  16  count of accepted rotate steps since lock, wraps modulo 2^16
revs  output  8  count of head wraps 15→0 since lock, wraps modulo 2^8
err  output  1  sticky fault flag, set on illegal transition

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On rst: state=IDLE, locked=0, err=0, switch_out=0, head=0, steps=0, revs=0, internal prev=0. Reset mid-operation aborts everything immediately; no state is retained.
- All outputs are registered and update on the clk edge that samples the qualifying input, so latency is 1 cycle.
- Legal shape (combinational, evaluated on led_in):
  - popcount L satisfies 1 ≤ L ≤ MAX_LEN, and
  - exactly one index i has led_in[i]=1 and led_in[(i+1) mod 16]=0. This is the circular-contiguity test.
- head = that index i. Run length L = popcount.
- Legal step: next = rotate-left-by-1(prev), i.e. {prev[14:0], prev[15]}.
- Legal hold: next == prev.
- FSM states: IDLE, TRACK, FAULT.
- IDLE:
  - sample with legal shape → TRACK. Set prev=led_in, locked=1, switch_out=L−1, head=i, steps=0, revs=0, err=0.
  - sample with illegal shape, including 0x0000 and 0xFFFF → remain IDLE. err is not set; outputs are unchanged.
- TRACK:
  - On sample, if led_in==prev: no change.
  - If led_in==rotl(prev): prev=led_in, head=head+1 mod 16, steps=steps+1. If old head==15, then revs=revs+1.
  - Otherwise → FAULT, err=1, locked=0. head, switch_out, steps and revs freeze at their last values.
- FAULT: all samples are ignored. err stays 1 until rst or resync.
- resync (any state) → IDLE with locked=0, err=0, steps=0, revs=0. head and switch_out are cleared to 0.
- resync and sample asserted in the same cycle: resync wins and the sample is dropped.
- No sample: all state holds.
- A run length change while in TRACK is an illegal transition and goes to FAULT.
- Counters wrap silently: steps 0xFFFF→0x0000, revs 0xFF→0x00. Wrap has no effect on err.

Test Plan:
- rst, then sample 0x0007 → next cycle locked=1, switch_out=2, head=2, steps=0, revs=0, err=0.
- From lock on 0x0007, sample 0x000E, 0x001C → head=4, steps=2. Sample 0x001C again (hold) → unchanged.
- Lock on 0xE000 (head=15), sample 0xC001 → head=0, revs=1, steps=1. Then 0x8003 → 0x0007 → head=2, steps=3.
- In TRACK on 0x000E, sample 0x0005 → err=1, locked=0, head stays 3. Further samples are ignored. resync pulse → IDLE, err=0. Then sample 0x00FF → locked=1, switch_out=7, head=7.
- In IDLE, sample 0x01FF (L=9), 0x0000, 0x0101 → locked stays 0, err stays 0.
- In TRACK with steps=5, assert rst asynchronously mid-cycle → all outputs 0 immediately. Separately, assert resync together with sample of a legal step → IDLE, sample dropped.

Source files
------------

// File: rtl/led_ring_decoder_if.sv
// Observation bus between an LED ring-shift source and its decoder.
// The master drives the sampled pattern and control; the slave reports lock status and counters.
interface led_ring_decoder_if;
  logic        sample;
  logic [15:0] led_in;
  logic        resync;
  logic        locked;
  logic [2:0]  switch_out;
  logic [3:0]  head;
  logic [15:0] steps;
  logic [7:0]  revs;
  logic        err;

  modport master (
    output sample, led_in, resync,
    input  locked, switch_out, head, steps, revs, err
  );

  modport slave (
    input  sample, led_in, resync,
    output locked, switch_out, head, steps, revs, err
  );
endinterface

// File: rtl/led_ring_decoder.sv
// Locks onto a circular run of ones on a 16-bit LED bus, follows its rotation,
// recovers the run length and counts steps/revolutions; any illegal move latches a fault.
module led_ring_decoder #(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  led_ring_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] prev_q, prev_d;
  logic [2:0]  switch_q, switch_d;
  logic [3:0]  head_q, head_d;
  logic [15:0] steps_q, steps_d;
  logic [7:0]  revs_q, revs_d;
  logic        err_q, err_d;

  // Shape analysis: a bit is a run end when its circular successor is zero.
  logic [15:0] led_next;
  logic [15:0] run_ends;
  logic [4:0]  run_len;
  logic [4:0]  n_ends;
  logic [3:0]  end_idx;
  logic        shape_ok;
  logic [15:0] prev_rotl;

  assign led_next  = {bus.led_in[0], bus.led_in[15:1]};
  assign run_ends  = bus.led_in & ~led_next;
  assign prev_rotl = {prev_q[14:0], prev_q[15]};

  always_comb begin
    run_len = 5'($countones(bus.led_in));
    n_ends  = 5'($countones(run_ends));
    end_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (run_ends[i]) end_idx = 4'(i);
    end
    shape_ok = (run_len >= 5'd1) && (run_len <= 5'(MAX_LEN)) && (n_ends == 5'd1);
  end

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    prev_d   = prev_q;
    switch_d = switch_q;
    head_d   = head_q;
    steps_d  = steps_q;
    revs_d   = revs_q;
    err_d    = err_q;

    if (bus.resync) begin
      state_d  = IDLE;
      prev_d   = '0;
      switch_d = '0;
      head_d   = '0;
      steps_d  = '0;
      revs_d   = '0;
      err_d    = 1'b0;
    end else if (bus.sample) begin
      unique case (state_q)
        IDLE: begin
          if (shape_ok) begin
            state_d  = TRACK;
            prev_d   = bus.led_in;
            switch_d = 3'(run_len - 5'd1);
            head_d   = end_idx;
            steps_d  = '0;
            revs_d   = '0;
            err_d    = 1'b0;
          end
        end
        TRACK: begin
          if (bus.led_in == prev_q) begin
            state_d = TRACK;
          end else if (bus.led_in == prev_rotl) begin
            prev_d  = bus.led_in;
            head_d  = head_q + 4'd1;
            steps_d = steps_q + 16'd1;
            if (head_q == 4'd15) revs_d = revs_q + 8'd1;
          end else begin
            // Counters and head freeze here so the failure point stays visible.
            state_d = FAULT;
            err_d   = 1'b1;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      switch_q <= '0;
      head_q   <= '0;
      steps_q  <= '0;
      revs_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make all registers see the pre-edge values, matching real flops.
      state_q  <= state_d;
      prev_q   <= prev_d;
      switch_q <= switch_d;
      head_q   <= head_d;
      steps_q  <= steps_d;
      revs_q   <= revs_d;
      err_q    <= err_d;
    end
  end

  assign bus.locked     = (state_q == TRACK);
  assign bus.switch_out = switch_q;
  assign bus.head       = head_q;
  assign bus.steps      = steps_q;
  assign bus.revs       = revs_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_led_ring_decoder.sv
// Bench for led_ring_decoder: directed and random stimulus against a pattern-level reference model,
// with expected outputs queued per cycle and compared by an independent monitor.
module tb_led_ring_decoder;

  localparam int MAX_LEN = 8;

  typedef enum {M_IDLE, M_TRACK, M_FAULT} mode_e;

  typedef struct {
    logic        locked;
    logic [2:0]  sw;
    logic [3:0]  head;
    logic [15:0] steps;
    logic [7:0]  revs;
    logic        err;
  } obs_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  led_ring_decoder_if bus ();

  led_ring_decoder #(.MAX_LEN(MAX_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, expressed in terms of patterns and counts.
  mode_e       m_mode;
  logic [15:0] m_prev;
  obs_t        m_out;
  obs_t        exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] p, input int n);
    logic [31:0] w;
    w = {p, p} << n;
    return w[31:16];
  endfunction

  // A legal shape is some run of L ones (1..MAX_LEN) rotated to a start position s.
  function automatic bit find_run(input logic [15:0] v, output int len, output int hd);
    logic [15:0] mask;
    len = 0;
    hd  = 0;
    for (int l = 1; l <= MAX_LEN; l++) begin
      mask = 16'((32'd1 << l) - 1);
      for (int s = 0; s < 16; s++) begin
        if (rotl(mask, s) == v) begin
          len = l;
          hd  = (s + l - 1) % 16;
          return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [15:0] rand_legal();
    logic [15:0] mask;
    mask = 16'((32'd1 << $urandom_range(1, MAX_LEN)) - 1);
    return rotl(mask, $urandom_range(0, 15));
  endfunction

  task automatic model_reset();
    m_mode       = M_IDLE;
    m_prev       = '0;
    m_out.locked = 1'b0;
    m_out.sw     = '0;
    m_out.head   = '0;
    m_out.steps  = '0;
    m_out.revs   = '0;
    m_out.err    = 1'b0;
  endtask

  task automatic model_cycle(input bit s, input logic [15:0] v, input bit r);
    int len;
    int hd;
    if (r) begin
      model_reset();
    end else if (s) begin
      case (m_mode)
        M_IDLE: begin
          if (find_run(v, len, hd)) begin
            m_mode      = M_TRACK;
            m_prev      = v;
            m_out.sw    = 3'(len - 1);
            m_out.head  = 4'(hd);
            m_out.steps = '0;
            m_out.revs  = '0;
            m_out.err   = 1'b0;
          end
        end
        M_TRACK: begin
          if (v == m_prev) begin
            m_mode = M_TRACK;
          end else if (v == rotl(m_prev, 1)) begin
            if (m_out.head == 4'd15) m_out.revs = 8'((int'(m_out.revs) + 1) % 256);
            m_prev      = v;
            m_out.head  = 4'((int'(m_out.head) + 1) % 16);
            m_out.steps = 16'((int'(m_out.steps) + 1) % 65536);
          end else begin
            m_mode    = M_FAULT;
            m_out.err = 1'b1;
          end
        end
        default: m_mode = M_FAULT;
      endcase
    end
    m_out.locked = (m_mode == M_TRACK);
  endtask

  task automatic cycle(input bit s, input logic [15:0] v, input bit r);
    bus.sample = s;
    bus.led_in = v;
    bus.resync = r;
    model_cycle(s, v, r);
    exp_q.push_back(m_out);
    @(posedge clk);
    #1;
    bus.sample = 1'b0;
    bus.resync = 1'b0;
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("locked", 32'(bus.locked), 32'(e.locked));
      check("switch_out", 32'(bus.switch_out), 32'(e.sw));
      check("head", 32'(bus.head), 32'(e.head));
      check("steps", 32'(bus.steps), 32'(e.steps));
      check("revs", 32'(bus.revs), 32'(e.revs));
      check("err", 32'(bus.err), 32'(e.err));
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(bus.locked), 32'd0);
    check({tag, "_switch_out"}, 32'(bus.switch_out), 32'd0);
    check({tag, "_head"}, 32'(bus.head), 32'd0);
    check({tag, "_steps"}, 32'(bus.steps), 32'd0);
    check({tag, "_revs"}, 32'(bus.revs), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic async_reset();
    drain();
    #1 rst = 1'b1;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int          r;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.sample = 1'b0;
    bus.led_in = '0;
    bus.resync = 1'b0;
    model_reset();

    #12 check_all_zero("reset");
    @(negedge clk);
    #1 rst = 1'b0;

    // Lock and step.
    cycle(1, 16'h0007, 0);
    check("lock7_locked", 32'(bus.locked), 32'd1);
    check("lock7_switch", 32'(bus.switch_out), 32'd2);
    check("lock7_head", 32'(bus.head), 32'd2);
    cycle(1, 16'h000E, 0);
    cycle(1, 16'h001C, 0);
    check("step2_head", 32'(bus.head), 32'd4);
    check("step2_steps", 32'(bus.steps), 32'd2);
    cycle(1, 16'h001C, 0);
    cycle(0, 16'h5555, 0);
    cycle(0, 16'h0000, 1);

    // Head wrap across bit 15.
    cycle(1, 16'hE000, 0);
    check("lockE_head", 32'(bus.head), 32'd15);
    cycle(1, 16'hC001, 0);
    check("wrap_head", 32'(bus.head), 32'd0);
    check("wrap_revs", 32'(bus.revs), 32'd1);
    check("wrap_steps", 32'(bus.steps), 32'd1);
    cycle(1, 16'h8003, 0);
    cycle(1, 16'h0007, 0);
    check("wrap3_head", 32'(bus.head), 32'd2);
    check("wrap3_steps", 32'(bus.steps), 32'd3);
    cycle(0, 16'h0000, 1);

    // Fault, ignored samples, resync, relock at full length.
    cycle(1, 16'h000E, 0);
    cycle(1, 16'h0005, 0);
    check("fault_err", 32'(bus.err), 32'd1);
    check("fault_locked", 32'(bus.locked), 32'd0);
    check("fault_head", 32'(bus.head), 32'd3);
    cycle(1, 16'h001C, 0);
    cycle(1, 16'h0001, 0);
    cycle(0, 16'h0000, 1);
    cycle(1, 16'h00FF, 0);
    check("lockFF_switch", 32'(bus.switch_out), 32'd7);
    check("lockFF_head", 32'(bus.head), 32'd7);
    cycle(0, 16'h0000, 1);

    // Illegal shapes in IDLE.
    cycle(1, 16'h01FF, 0);
    cycle(1, 16'h0000, 0);
    cycle(1, 16'h0101, 0);
    cycle(1, 16'hFFFF, 0);
    check("idle_illegal_locked", 32'(bus.locked), 32'd0);
    check("idle_illegal_err", 32'(bus.err), 32'd0);

    // Run length change while tracking.
    cycle(1, 16'h0007, 0);
    cycle(1, 16'h000F, 0);
    check("lenchg_err", 32'(bus.err), 32'd1);
    cycle(0, 16'h0000, 1);

    // Resync beats a simultaneous legal step.
    cycle(1, 16'h0003, 0);
    cycle(1, 16'h0006, 1);
    check("resync_wins_locked", 32'(bus.locked), 32'd0);
    check("resync_wins_head", 32'(bus.head), 32'd0);

    // Asynchronous reset mid-cycle after five steps.
    cycle(1, 16'h0001, 0);
    v = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      v = rotl(v, 1);
      cycle(1, v, 0);
    end
    check("pre_rst_steps", 32'(bus.steps), 32'd5);
    async_reset();

    // Revolution counter wrap: 4099 steps from head 0.
    cycle(1, 16'h0001, 0);
    v = 16'h0001;
    for (int i = 0; i < 4099; i++) begin
      v = rotl(v, 1);
      cycle(1, v, 0);
    end
    check("revwrap_revs", 32'(bus.revs), 32'd0);
    check("revwrap_head", 32'(bus.head), 32'd3);
    check("revwrap_steps", 32'(bus.steps), 32'd4099);
    cycle(0, 16'h0000, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: v = rotl(m_prev, 1);
        5, 6:          v = m_prev;
        7:             v = rand_legal();
        8:             v = 16'($urandom());
        default:       v = rotl(m_prev, 1) ^ (16'd1 << $urandom_range(0, 15));
      endcase
      if (m_mode == M_IDLE && r < 40) v = rand_legal();
      cycle(r >= 10, v, (r < 3) || (m_mode == M_FAULT && r < 15));
    end

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
